wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port at the end of the MIPS pipeline. It shares the port between the in-order writeback stage (the MemtoReg mux result) and a multi-cycle multiply/divide unit that completes out of band. The pipeline has priority, with two exceptions: a same-destination conflict and a starvation limit. In either case the arbiter stalls the pipeline and grants the multi-cycle unit. All register-file write signals are registered, so the write lands one cycle after the grant.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width
- STARVE_LIMIT, 3, maximum consecutive ungranted cycles for md_req (legal range 1..15)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- pipe_valid  in  1  WB stage holds a valid instruction
- pipe_regwrite  in  1  WB instruction writes a register
- pipe_rd  in  ADDR_W  WB destination register
- pipe_result  in  DATA_W  WB mux output (ALU result or load data)
- pipe_stall  out  1  combinational; WB stage must hold all pipe_* inputs stable and the upstream pipeline must freeze
- md_req  in  1  multi-cycle unit has a result; held high with stable md_rd/md_result until acked
- md_rd  in  ADDR_W  multi-cycle destination register
- md_result  in  DATA_W  multi-cycle result
- md_ack  out  1  combinational, one-cycle grant; the multi-cycle unit drops or replaces the request next cycle
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  ADDR_W  registered write address
- rf_wdata  out  DATA_W  registered write data
- stall_count  out  CNT_W  saturating count of cycles with pipe_stall=1

## Operation
- pw = pipe_valid & pipe_regwrite & (pipe_rd != 0). A pipeline write to r0 is treated as no write.
- conflict = md_req & pw & (pipe_rd == md_rd).
- force = md_req & (starve_cnt == STARVE_LIMIT).
- grant_md = md_req & (!pw | conflict | force).
- md_ack = grant_md.
- pipe_stall = pw & grant_md. The multi-cycle result is older, so on conflict it writes first and the pipeline write follows.
- An md request with md_rd == 0 is acked, produces no write, and does not stall the pipeline unless force or conflict also applies.
- FSM, two states:
  - IDLE: starve_cnt = 0. IDLE→MD_WAIT when md_req & !grant_md.
  - MD_WAIT: starve_cnt increments each ungranted cycle. MD_WAIT→IDLE on grant_md or when md_req drops; starve_cnt clears to 0 in both cases.
  - md_req deasserting before ack is a protocol violation. The arbiter still returns to IDLE and clears the counter.
- Write port, next edge:
  - if grant_md & md_rd != 0: rf_we=1, rf_waddr=md_rd, rf_wdata=md_result
  - else if pw: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_result
  - else: rf_we=0, and waddr/wdata hold their previous values
- stall_count increments when pipe_stall=1 and saturates at all-ones.

## Timing
- Reset, while rst_n=0 at a rising edge:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - state=IDLE, starve_cnt=0, stall_count=0
  - md_ack and pipe_stall are forced to 0 combinationally for as long as rst_n=0
- Reset mid-wait drops the pending grant. The multi-cycle unit re-presents its request after reset.
- Latency: a grant in cycle N writes the register file at the edge ending cycle N. rf_* are valid throughout cycle N+1.
- Worst-case md wait: with pw continuously high, md_req is granted in its (STARVE_LIMIT+1)th cycle.
- A stalled pipeline write is re-evaluated the next cycle. It always wins that cycle unless a new md request forces or conflicts.
- Simultaneous conflict and force: one grant, one stall cycle.
- Back-to-back md requests with continuous pw: at most one forced stall per STARVE_LIMIT+1 cycles.

## Test plan
- Reset: hold rst_n=0 with md_req=1 and pw=1 → rf_we=0, md_ack=0, pipe_stall=0, stall_count=0.
- Idle md: pw=0, md_req=1, md_rd=8, md_result=32'h8C123456 → md_ack=1 and pipe_stall=0 the same cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=32'h8C123456.
- Pipeline priority and starvation: pw=1 every cycle (pipe_rd=3, pipe_result=32'h002300AA), md_req=1 (md_rd=9) from cycle 0 → md_ack=0 in cycles 0-2; md_ack=1 and pipe_stall=1 in cycle 3; r9 written after cycle 3 and r3 after cycle 4; stall_count=1.
- Conflict: pw with pipe_rd=5 and pipe_result=32'h10654321, plus md_req with md_rd=5 and md_result=32'hAD654321, same cycle → stall; writes in order r5=32'hAD654321, then r5=32'h10654321.
- r0 handling: pipe_rd=0 with pipe_valid=1 and pipe_regwrite=1 → rf_we=0; md_rd=0 → md_ack=1, rf_we=0, no stall.
- Saturation: with CNT_W=4, force 20 stall cycles → stall_count ends at 4'hF.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the
// in-order writeback stage and an out-of-band multiply/divide unit.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic              pipe_regwrite,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_result,
  output logic              pipe_stall,
  input  logic              md_req,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_result,
  output logic              md_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  stall_count,
  output logic              dbg_state
);

  // Handshakes: md_req is a level request held with stable md_rd/md_result
  // until md_ack is seen high in a cycle; md_ack is a single-cycle grant.
  // pipe_stall high means the WB stage holds its pipe_* inputs into the next
  // cycle, where the same write is presented and arbitrated again.

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state;
  logic [3:0]  starve_cnt;
  logic        pw;
  logic        conflict;
  logic        force_md;
  logic        grant_md;
  logic        stall_int;

  always_comb begin
    pw        = pipe_valid & pipe_regwrite & (pipe_rd != '0);
    conflict  = md_req & pw & (pipe_rd == md_rd);
    force_md  = md_req & (starve_cnt == LIMIT);
    grant_md  = md_req & (~pw | conflict | force_md);
    stall_int = pw & grant_md;
  end

  // Grants are suppressed during reset so nothing is consumed while held.
  assign md_ack     = rst_n & grant_md;
  assign pipe_stall = rst_n & stall_int;
  assign dbg_state  = (state == MD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      stall_count <= '0;
    end else begin
      // The ungranted cycle spent in IDLE already counts toward starvation.
      case (state)
        IDLE: begin
          if (md_req && !grant_md) begin
            state      <= MD_WAIT;
            starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (grant_md || !md_req) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= '0;
        end
      endcase

      if (grant_md && (md_rd != '0)) begin
        rf_we    <= 1'b1;
        rf_waddr <= md_rd;
        rf_wdata <= md_result;
      end else if (pw) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_result;
      end else begin
        rf_we <= 1'b0;
      end

      if (stall_int && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// by the driver and checked in order by a monitor watching rf_we.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int WR_W   = ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              pipe_valid;
  logic              pipe_regwrite;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_result;
  logic              pipe_stall;
  logic              md_req;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_result;
  logic              md_ack;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  stall_count;
  logic              dbg_state;

  logic [WR_W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_regwrite(pipe_regwrite),
    .pipe_rd(pipe_rd), .pipe_result(pipe_result), .pipe_stall(pipe_stall),
    .md_req(md_req), .md_rd(md_rd), .md_result(md_result), .md_ack(md_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: each cycle starts 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic w, input logic [ADDR_W-1:0] rd,
                          input logic [DATA_W-1:0] res);
    pipe_valid    = v;
    pipe_regwrite = w;
    pipe_rd       = rd;
    pipe_result   = res;
  endtask

  task automatic set_md(input logic req, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] res);
    md_req    = req;
    md_rd     = rd;
    md_result = res;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_pipe(1'b0, 1'b0, '0, '0);
    set_md(1'b0, '0, '0);

    // Scoreboard monitor: every write seen on the port must match the queue head.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rf_we) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                     rf_waddr, rf_wdata);
          end else begin
            logic [WR_W-1:0] e;
            e = exp_q.pop_front();
            check("rf_write", {32'h0, rf_waddr, rf_wdata}, {32'h0, e});
          end
        end
      end
    join_none

    // Reset held with live requests on both sides.
    set_pipe(1'b1, 1'b1, 5'd3, 32'h1111_2222);
    set_md(1'b1, 5'd9, 32'h3333_4444);
    repeat (3) next_cycle();
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_waddr", 64'(rf_waddr), 64'd0);
    check("reset_md_ack", 64'(md_ack), 64'd0);
    check("reset_stall", 64'(pipe_stall), 64'd0);
    check("reset_stall_count", 64'(stall_count), 64'd0);
    set_pipe(1'b0, 1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    rst_n = 1'b1;
    next_cycle();

    // Idle md request is granted immediately.
    set_md(1'b1, 5'd8, 32'h8C12_3456);
    #1;
    check("idle_md_ack", 64'(md_ack), 64'd1);
    check("idle_md_stall", 64'(pipe_stall), 64'd0);
    expect_write(5'd8, 32'h8C12_3456);
    next_cycle();
    set_md(1'b0, '0, '0);
    #1;
    check("idle_rf_we", 64'(rf_we), 64'd1);
    next_cycle();

    // Continuous pipeline writes starve md until the 4th cycle.
    for (int c = 0; c < 5; c++) begin
      set_pipe(1'b1, 1'b1, 5'd3, 32'h0023_00AA);
      if (c < 4) set_md(1'b1, 5'd9, 32'h0999_0009);
      else       set_md(1'b0, '0, '0);
      #1;
      check($sformatf("starve_ack_c%0d", c), 64'(md_ack), (c == 3) ? 64'd1 : 64'd0);
      check($sformatf("starve_stall_c%0d", c), 64'(pipe_stall), (c == 3) ? 64'd1 : 64'd0);
      if (c == 1 || c == 2) check($sformatf("starve_state_c%0d", c), 64'(dbg_state), 64'd1);
      if (c == 3) expect_write(5'd9, 32'h0999_0009);
      else        expect_write(5'd3, 32'h0023_00AA);
      next_cycle();
    end
    set_pipe(1'b0, 1'b0, '0, '0);
    #1;
    check("starve_stall_count", 64'(stall_count), 64'd1);
    check("starve_state_idle", 64'(dbg_state), 64'd0);

    // Same-destination conflict: md writes first, pipeline follows.
    next_cycle();
    set_pipe(1'b1, 1'b1, 5'd5, 32'h1065_4321);
    set_md(1'b1, 5'd5, 32'hAD65_4321);
    #1;
    check("conflict_ack", 64'(md_ack), 64'd1);
    check("conflict_stall", 64'(pipe_stall), 64'd1);
    expect_write(5'd5, 32'hAD65_4321);
    next_cycle();
    set_md(1'b0, '0, '0);
    #1;
    check("conflict_retry_stall", 64'(pipe_stall), 64'd0);
    expect_write(5'd5, 32'h1065_4321);
    next_cycle();
    set_pipe(1'b0, 1'b0, '0, '0);
    #1;
    check("conflict_stall_count", 64'(stall_count), 64'd2);

    // r0 destinations produce no write.
    next_cycle();
    set_pipe(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("r0_pipe_stall", 64'(pipe_stall), 64'd0);
    next_cycle();
    set_pipe(1'b0, 1'b0, '0, '0);
    set_md(1'b1, 5'd0, 32'hCAFE_F00D);
    #1;
    check("r0_pipe_rf_we", 64'(rf_we), 64'd0);
    check("r0_md_ack", 64'(md_ack), 64'd1);
    check("r0_md_stall", 64'(pipe_stall), 64'd0);
    next_cycle();
    set_md(1'b0, '0, '0);
    #1;
    check("r0_md_rf_we", 64'(rf_we), 64'd0);
    next_cycle();

    // 20 conflict stalls drive the 4-bit counter into saturation.
    set_pipe(1'b1, 1'b1, 5'd7, 32'h0000_0077);
    for (int i = 0; i < 20; i++) begin
      set_md(1'b1, 5'd7, 32'h100 + 32'(i));
      #1;
      check($sformatf("sat_stall_%0d", i), 64'(pipe_stall), 64'd1);
      expect_write(5'd7, 32'h100 + 32'(i));
      next_cycle();
    end
    set_md(1'b0, '0, '0);
    #1;
    check("sat_release_stall", 64'(pipe_stall), 64'd0);
    expect_write(5'd7, 32'h0000_0077);
    next_cycle();
    set_pipe(1'b0, 1'b0, '0, '0);
    #1;
    check("sat_stall_count", 64'(stall_count), 64'hF);

    repeat (3) next_cycle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
